// File: rtl/addsub_arbiter_if.sv
// Requester, response and shared adder/subtracter signals of addsub_arbiter.
// The arbiter takes the slave modport; the environment (requesters and the shared unit) takes master.
interface addsub_arbiter_if #(
   parameter int WIDTH = 4,
   parameter int NREQ  = 4
);
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic [NREQ-1:0]       req_sub;
   logic [NREQ-1:0]       rsp_valid;
   logic [NREQ-1:0]       rsp_ready;
   logic [WIDTH-1:0]      rsp_sum;
   logic                  rsp_v;
   logic [WIDTH-1:0]      au_a;
   logic [WIDTH-1:0]      au_b;
   logic                  au_s;
   logic [WIDTH-1:0]      au_sum;
   logic                  au_v;

   modport master (
      output req_valid, req_a, req_b, req_sub, rsp_ready, au_sum, au_v,
      input  req_ready, rsp_valid, rsp_sum, rsp_v, au_a, au_b, au_s
   );

   modport slave (
      input  req_valid, req_a, req_b, req_sub, rsp_ready, au_sum, au_v,
      output req_ready, rsp_valid, rsp_sum, rsp_v, au_a, au_b, au_s
   );
endinterface

// File: rtl/addsub_arbiter.sv
// Round-robin time-sharing of one external adder/subtracter among NREQ requesters; accept -> rsp_valid in 2 cycles.
// Optional ADDSUB_ARB_STATS_EN adds saturating op_count/ovf_count outputs.
module addsub_arbiter #(
   parameter int WIDTH = 4,
   parameter int NREQ  = 4
) (
   input  logic                clk,
   input  logic                rst,
   addsub_arbiter_if.slave     bus
`ifdef ADDSUB_ARB_STATS_EN
   ,
   output logic [15:0]         op_count,
   output logic [15:0]         ovf_count
`endif
);
   localparam int IW = $clog2(NREQ);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t           state;
   logic [IW-1:0]    last_grant;
   logic [IW-1:0]    grant;
   logic [IW-1:0]    pick;
   logic             found;
   logic [NREQ-1:0]  pick_oh;
   logic [NREQ-1:0]  grant_oh;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;
   logic             sel_sub;
   logic             done;

   // Scan distances from NREQ down to 1 so the nearest requester after last_grant wins.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      for (int k = NREQ; k >= 1; k--) begin
         for (int i = 0; i < NREQ; i++) begin
            if (bus.req_valid[i] && (((int'(last_grant) + k) % NREQ) == i)) begin
               found = 1'b1;
               pick  = IW'(i);
            end
         end
      end
   end

   always_comb begin
      sel_a    = '0;
      sel_b    = '0;
      sel_sub  = 1'b0;
      pick_oh  = '0;
      grant_oh = '0;
      done     = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         pick_oh[i]  = found && (pick == IW'(i));
         grant_oh[i] = (grant == IW'(i));
         if (pick == IW'(i)) begin
            sel_a   = bus.req_a[i*WIDTH +: WIDTH];
            sel_b   = bus.req_b[i*WIDTH +: WIDTH];
            sel_sub = bus.req_sub[i];
         end
         if ((state == RESP) && (grant == IW'(i)) && bus.rsp_ready[i])
            done = 1'b1;
      end
   end

   assign bus.req_ready = ((state == IDLE) && !rst) ? pick_oh : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         last_grant    <= IW'(NREQ - 1);
         grant         <= '0;
         bus.rsp_valid <= '0;
         bus.rsp_sum   <= '0;
         bus.rsp_v     <= 1'b0;
         bus.au_a      <= '0;
         bus.au_b      <= '0;
         bus.au_s      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  bus.au_a <= sel_a;
                  bus.au_b <= sel_b;
                  bus.au_s <= sel_sub;
                  grant    <= pick;
                  state    <= EXEC;
               end
            end
            EXEC: begin
               bus.rsp_sum   <= bus.au_sum;
               bus.rsp_v     <= bus.au_v;
               bus.rsp_valid <= grant_oh;
               state         <= RESP;
            end
            RESP: begin
               // The pointer advances only on completion, so the next scan starts after this owner.
               if (done) begin
                  bus.rsp_valid <= '0;
                  last_grant    <= grant;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ADDSUB_ARB_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_count  <= '0;
         ovf_count <= '0;
      end else if (done) begin
         if (op_count != 16'hFFFF)
            op_count <= op_count + 16'd1;
         if (bus.rsp_v && (ovf_count != 16'hFFFF))
            ovf_count <= ovf_count + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_addsub_arbiter.sv
// Bench for addsub_arbiter: directed cases then randomized traffic checked against a signed-integer model.
// Models the shared adder/subtracter as a combinational unit on the interface.
module tb_addsub_arbiter;
   localparam int W = 4;
   localparam int N = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   addsub_arbiter_if #(.WIDTH(W), .NREQ(N)) bus ();

`ifdef ADDSUB_ARB_STATS_EN
   logic [15:0] op_count;
   logic [15:0] ovf_count;
`endif

   addsub_arbiter #(.WIDTH(W), .NREQ(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef ADDSUB_ARB_STATS_EN
      ,
      .op_count  (op_count),
      .ovf_count (ovf_count)
`endif
   );

   // External shared unit.
   logic [W-1:0] bx;
   assign bx         = bus.au_b ^ {W{bus.au_s}};
   assign bus.au_sum = bus.au_a + bx + {{(W-1){1'b0}}, bus.au_s};
   assign bus.au_v   = (bus.au_a[W-1] == bx[W-1]) && (bus.au_sum[W-1] != bus.au_a[W-1]);

   int         checks = 0;
   int         passed = 0;
   int         lg;
   int         n_ops;
   int         n_ovf;
   logic [W-1:0] pa [N];
   logic [W-1:0] pb [N];
   logic         ps [N];
   bit           pend [N];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic void ref_calc(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                    output logic [W-1:0] sum, output logic v);
      int sa, sb, r;
      sa  = int'($signed(a));
      sb  = int'($signed(b));
      r   = s ? (sa - sb) : (sa + sb);
      v   = (r > (2 ** (W - 1)) - 1) || (r < -(2 ** (W - 1)));
      sum = r[W-1:0];
   endfunction

   task automatic apply();
      for (int i = 0; i < N; i++) begin
         bus.req_valid[i]       = pend[i];
         bus.req_a[i*W +: W]    = pa[i];
         bus.req_b[i*W +: W]    = pb[i];
         bus.req_sub[i]         = ps[i];
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check("rst.req_ready", bus.req_ready, 0);
      check("rst.rsp_valid", bus.rsp_valid, 0);
      check("rst.rsp_sum", bus.rsp_sum, 0);
      check("rst.rsp_v", bus.rsp_v, 0);
      check("rst.au_a", bus.au_a, 0);
      check("rst.au_b", bus.au_b, 0);
      check("rst.au_s", bus.au_s, 0);
`ifdef ADDSUB_ARB_STATS_EN
      check("rst.op_count", op_count, 0);
      check("rst.ovf_count", ovf_count, 0);
`endif
      @(posedge clk); #1;
      rst   = 1'b0;
      lg    = N - 1;
      n_ops = 0;
      n_ovf = 0;
   endtask

   // Starts in an IDLE cycle just after a rising edge; returns at the start of the next IDLE cycle.
   task automatic transact(input int hold, input bit keep, input string tag);
      int           g;
      logic [W-1:0] es;
      logic         ev;
      logic [N-1:0] oh;
      g = -1;
      for (int k = 1; k <= N; k++)
         if (g < 0 && pend[(lg + k) % N]) g = (lg + k) % N;
      if (g < 0) begin
         g = 0;
         pend[0] = 1'b1;
      end
      ref_calc(pa[g], pb[g], ps[g], es, ev);
      oh = N'(1) << g;
      apply();
      bus.rsp_ready = (hold > 0) ? ~oh : '1;
      @(negedge clk);
      check({tag, ".grant"}, bus.req_ready, oh);
      check({tag, ".idle_rsp_valid"}, bus.rsp_valid, 0);
      @(posedge clk); #1;
      if (!keep) pend[g] = 1'b0;
      apply();
      @(negedge clk);
      check({tag, ".exec_req_ready"}, bus.req_ready, 0);
      check({tag, ".exec_rsp_valid"}, bus.rsp_valid, 0);
      check({tag, ".au_a"}, bus.au_a, pa[g]);
      check({tag, ".au_b"}, bus.au_b, pb[g]);
      check({tag, ".au_s"}, bus.au_s, ps[g]);
      @(posedge clk); #1;
      @(negedge clk);
      check({tag, ".rsp_valid"}, bus.rsp_valid, oh);
      check({tag, ".rsp_sum"}, bus.rsp_sum, es);
      check({tag, ".rsp_v"}, bus.rsp_v, ev);
      check({tag, ".resp_req_ready"}, bus.req_ready, 0);
      for (int j = 1; j <= hold; j++) begin
         @(posedge clk); #1;
         if (j == hold) bus.rsp_ready = '1;
         @(negedge clk);
         check({tag, ".hold_rsp_valid"}, bus.rsp_valid, oh);
         check({tag, ".hold_rsp_sum"}, bus.rsp_sum, es);
         check({tag, ".hold_req_ready"}, bus.req_ready, 0);
      end
      @(posedge clk); #1;
      lg = g;
      n_ops++;
      if (ev) n_ovf++;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int any;
      for (int i = 0; i < N; i++) begin
         pend[i] = 1'b0; pa[i] = '0; pb[i] = '0; ps[i] = 1'b0;
      end
      bus.rsp_ready = '0;
      pend[0] = 1'b1; pa[0] = 4'd3; pb[0] = 4'd4; ps[0] = 1'b0;
      apply();
      do_reset();

      transact(0, 1'b0, "add_3_4");
      pend[1] = 1'b1; pa[1] = 4'b0111; pb[1] = 4'b1000; ps[1] = 1'b1;
      transact(0, 1'b0, "sub_ovf");
      pend[2] = 1'b1; pa[2] = 4'd1; pb[2] = 4'd1; ps[2] = 1'b0;
      transact(0, 1'b0, "add_1_1");
`ifdef ADDSUB_ARB_STATS_EN
      check("stats.op_count", op_count, n_ops);
      check("stats.ovf_count", ovf_count, n_ovf);
`endif

      // All requesters held valid from reset: rotation 0,1,2,3,0.
      for (int i = 0; i < N; i++) begin
         pend[i] = 1'b1; pa[i] = W'($urandom); pb[i] = W'($urandom); ps[i] = 1'($urandom);
      end
      apply();
      do_reset();
      for (int r = 0; r < 5; r++) transact(0, 1'b1, "rotate");
      check("rotate.last", lg, 0);
      for (int i = 0; i < N; i++) pend[i] = 1'b0;

      // Response held off while another requester waits.
      pend[2] = 1'b1; pa[2] = 4'd2; pb[2] = 4'd5; ps[2] = 1'b1;
      pend[0] = 1'b1; pa[0] = W'($urandom); pb[0] = W'($urandom); ps[0] = 1'($urandom);
      transact(5, 1'b0, "hold2");
      transact(0, 1'b0, "after_hold");

      // Reset during EXEC discards the operation and restores priority to requester 0.
      pend[3] = 1'b1; pa[3] = 4'd5; pb[3] = 4'd6; ps[3] = 1'b0;
      apply();
      bus.rsp_ready = '1;
      @(negedge clk);
      check("rst_exec.grant", bus.req_ready, 4'b1000);
      @(posedge clk); #1;
      pend[0] = 1'b1; pa[0] = 4'd6; pb[0] = 4'd7; ps[0] = 1'b0;
      apply();
      do_reset();
      transact(0, 1'b0, "post_rst0");
      transact(0, 1'b0, "post_rst3");

      // Randomized traffic.
      for (int it = 0; it < 40; it++) begin
         any = 0;
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
               pend[i] = 1'b1; pa[i] = W'($urandom); pb[i] = W'($urandom); ps[i] = 1'($urandom);
            end
            if (pend[i]) any++;
         end
         if (any == 0) begin
            pend[it % N] = 1'b1; pa[it % N] = W'($urandom); pb[it % N] = W'($urandom);
            ps[it % N] = 1'($urandom);
         end
         transact($urandom_range(0, 3), 1'b0, "rand");
      end
      @(negedge clk);
      check("final.rsp_valid", bus.rsp_valid, 0);
`ifdef ADDSUB_ARB_STATS_EN
      check("final.op_count", op_count, n_ops);
      check("final.ovf_count", ovf_count, n_ovf);
`endif

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
